dmem_ctrl: RTL and testbench

Data memory controller between the core's data memory port and a single-master synchronous memory bus with acknowledge. It turns each load or store from the core into one bus transaction, stalls the core until the bus completes, and returns load data. It also flags misaligned accesses, bus errors and bus timeouts.

---
 rtl/dmem_ctrl.sv | 154 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Data memory controller: one bus transaction per core load/store, min 3 cycles (2 stalled), misaligned 2 cycles.
// Core is held via o_stall until ack, err or timeout; bus outputs are registered, requests are only sampled in IDLE.
module dmem_ctrl #(
   parameter int DATA_WIDTH_P      = 32,
   parameter int DATA_ADDR_WIDTH_P = 32,
   parameter int TIMEOUT_P         = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         i_mem_rd_en,
   input  logic                         i_mem_wr_en,
   input  logic [DATA_ADDR_WIDTH_P-1:0] i_mem_addr,
   input  logic [DATA_WIDTH_P-1:0]      i_mem_wr_data,
   output logic [DATA_WIDTH_P-1:0]      o_mem_rd_data,
   output logic                         o_stall,
   output logic                         o_err,
   output logic [7:0]                   o_err_count,
   output logic                         o_bus_cyc,
   output logic                         o_bus_we,
   output logic [DATA_ADDR_WIDTH_P-1:0] o_bus_addr,
   output logic [DATA_WIDTH_P-1:0]      o_bus_wr_data,
   input  logic [DATA_WIDTH_P-1:0]      i_bus_rd_data,
   input  logic                         i_bus_ack,
   input  logic                         i_bus_err
);

   localparam int            CNT_W    = (TIMEOUT_P > 1) ? $clog2(TIMEOUT_P) : 1;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_P - 1);
   localparam logic [CNT_W-1:0] TMO_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                  state_q;
   state_t                  state_nxt;
   logic [CNT_W-1:0]        tmo_cnt;
   logic [DATA_WIDTH_P-1:0] rd_data_q;
   logic                    err_q;

   logic req;
   logic aligned;
   logic accept;
   logic misalign;
   logic evt_err;
   logic evt_ack;
   logic evt_tmo;

   assign req     = i_mem_rd_en | i_mem_wr_en;
   assign aligned = (i_mem_addr[1:0] == 2'b00);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // err outranks ack, which outranks the timeout, so an ack on the last allowed cycle still succeeds
   always_comb begin
      state_nxt = state_q;
      o_stall   = 1'b0;
      accept    = 1'b0;
      misalign  = 1'b0;
      evt_err   = 1'b0;
      evt_ack   = 1'b0;
      evt_tmo   = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               o_stall = 1'b1;
               if (aligned) begin
                  accept    = 1'b1;
                  state_nxt = BUS;
               end else begin
                  misalign  = 1'b1;
                  state_nxt = DONE;
               end
            end
         end
         BUS: begin
            o_stall = 1'b1;
            if (i_bus_err) begin
               evt_err = 1'b1;
            end else if (i_bus_ack) begin
               evt_ack = 1'b1;
            end else if (tmo_cnt == TMO_LAST) begin
               evt_tmo = 1'b1;
            end
            if (i_bus_err || i_bus_ack || (tmo_cnt == TMO_LAST)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_bus_cyc     <= 1'b0;
         o_bus_we      <= 1'b0;
         o_bus_addr    <= '0;
         o_bus_wr_data <= '0;
         rd_data_q     <= '0;
         err_q         <= 1'b0;
         tmo_cnt       <= '0;
      end else begin
         if (accept) begin
            o_bus_cyc     <= 1'b1;
            o_bus_we      <= i_mem_wr_en;
            o_bus_addr    <= {i_mem_addr[DATA_ADDR_WIDTH_P-1:2], 2'b00};
            o_bus_wr_data <= i_mem_wr_data;
            tmo_cnt       <= '0;
            err_q         <= 1'b0;
            rd_data_q     <= '0;
         end
         if (misalign) begin
            err_q     <= 1'b1;
            rd_data_q <= '0;
         end
         if (evt_err || evt_tmo) begin
            o_bus_cyc <= 1'b0;
            err_q     <= 1'b1;
            rd_data_q <= '0;
         end else if (evt_ack) begin
            o_bus_cyc <= 1'b0;
            err_q     <= 1'b0;
            rd_data_q <= o_bus_we ? '0 : i_bus_rd_data;
         end else if (state_q == BUS) begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_err_count <= 8'd0;
      end else if ((state_q == DONE) && err_q && (o_err_count != 8'hFF)) begin
         o_err_count <= o_err_count + 8'd1;
      end
   end

   assign o_mem_rd_data = (state_q == DONE) ? rd_data_q : '0;
   assign o_err         = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: loads, stores, misalignment, timeout, ack/err priority, reset mid-bus, saturation.
module tb_dmem_ctrl;

   logic        clk;
   logic        reset;
   logic        i_mem_rd_en;
   logic        i_mem_wr_en;
   logic [31:0] i_mem_addr;
   logic [31:0] i_mem_wr_data;
   logic [31:0] o_mem_rd_data;
   logic        o_stall;
   logic        o_err;
   logic [7:0]  o_err_count;
   logic        o_bus_cyc;
   logic        o_bus_we;
   logic [31:0] o_bus_addr;
   logic [31:0] o_bus_wr_data;
   logic [31:0] i_bus_rd_data;
   logic        i_bus_ack;
   logic        i_bus_err;

   int n_assert = 0;
   int n_fail   = 0;

   dmem_ctrl #(
      .DATA_WIDTH_P      (32),
      .DATA_ADDR_WIDTH_P (32),
      .TIMEOUT_P         (4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .i_mem_rd_en   (i_mem_rd_en),
      .i_mem_wr_en   (i_mem_wr_en),
      .i_mem_addr    (i_mem_addr),
      .i_mem_wr_data (i_mem_wr_data),
      .o_mem_rd_data (o_mem_rd_data),
      .o_stall       (o_stall),
      .o_err         (o_err),
      .o_err_count   (o_err_count),
      .o_bus_cyc     (o_bus_cyc),
      .o_bus_we      (o_bus_we),
      .o_bus_addr    (o_bus_addr),
      .o_bus_wr_data (o_bus_wr_data),
      .i_bus_rd_data (i_bus_rd_data),
      .i_bus_ack     (i_bus_ack),
      .i_bus_err     (i_bus_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   int cyc_cnt;

   initial begin
      reset         = 1'b1;
      i_mem_rd_en   = 1'b0;
      i_mem_wr_en   = 1'b0;
      i_mem_addr    = 32'h0;
      i_mem_wr_data = 32'h0;
      i_bus_rd_data = 32'h0;
      i_bus_ack     = 1'b0;
      i_bus_err     = 1'b0;
      #2;
      chk("rst_bus_cyc",  32'(o_bus_cyc), 32'd0);
      chk("rst_bus_we",   32'(o_bus_we), 32'd0);
      chk("rst_bus_addr", o_bus_addr, 32'h0);
      chk("rst_bus_wdat", o_bus_wr_data, 32'h0);
      chk("rst_stall",    32'(o_stall), 32'd0);
      chk("rst_err",      32'(o_err), 32'd0);
      chk("rst_rd_data",  o_mem_rd_data, 32'h0);
      chk("rst_err_cnt",  32'(o_err_count), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      cyc();

      // aligned load, ack in second bus cycle
      i_mem_rd_en = 1'b1;
      i_mem_addr  = 32'h0000_0010;
      #1;
      chk("ld_idle_stall", 32'(o_stall), 32'd1);
      chk("ld_idle_cyc",   32'(o_bus_cyc), 32'd0);
      cyc();
      i_mem_addr = 32'h0000_0044;
      chk("ld_b1_cyc",  32'(o_bus_cyc), 32'd1);
      chk("ld_b1_we",   32'(o_bus_we), 32'd0);
      chk("ld_b1_addr", o_bus_addr, 32'h10);
      chk("ld_b1_stall", 32'(o_stall), 32'd1);
      cyc();
      chk("ld_b2_cyc",  32'(o_bus_cyc), 32'd1);
      chk("ld_b2_addr", o_bus_addr, 32'h10);
      i_bus_ack     = 1'b1;
      i_bus_rd_data = 32'hDEAD_BEEF;
      cyc();
      i_bus_ack = 1'b0;
      #1;
      chk("ld_done_data",  o_mem_rd_data, 32'hDEAD_BEEF);
      chk("ld_done_stall", 32'(o_stall), 32'd0);
      chk("ld_done_err",   32'(o_err), 32'd0);
      chk("ld_done_cyc",   32'(o_bus_cyc), 32'd0);
      i_mem_rd_en = 1'b0;
      cyc();
      chk("ld_after_cyc",  32'(o_bus_cyc), 32'd0);
      chk("ld_after_data", o_mem_rd_data, 32'h0);

      // store with both enables high, ack in first bus cycle
      i_mem_rd_en   = 1'b1;
      i_mem_wr_en   = 1'b1;
      i_mem_addr    = 32'h0000_0020;
      i_mem_wr_data = 32'h1234_5678;
      #1;
      chk("st_idle_stall", 32'(o_stall), 32'd1);
      cyc();
      chk("st_b1_cyc",  32'(o_bus_cyc), 32'd1);
      chk("st_b1_we",   32'(o_bus_we), 32'd1);
      chk("st_b1_addr", o_bus_addr, 32'h20);
      chk("st_b1_wdat", o_bus_wr_data, 32'h1234_5678);
      i_bus_ack     = 1'b1;
      i_bus_rd_data = 32'hFFFF_FFFF;
      cyc();
      i_bus_ack = 1'b0;
      #1;
      chk("st_done_stall", 32'(o_stall), 32'd0);
      chk("st_done_err",   32'(o_err), 32'd0);
      chk("st_done_data",  o_mem_rd_data, 32'h0);
      i_mem_rd_en = 1'b0;
      i_mem_wr_en = 1'b0;
      cyc();

      // misaligned load
      i_mem_rd_en = 1'b1;
      i_mem_addr  = 32'h0000_0013;
      #1;
      chk("mis_idle_stall", 32'(o_stall), 32'd1);
      cyc();
      chk("mis_done_cyc",   32'(o_bus_cyc), 32'd0);
      chk("mis_done_err",   32'(o_err), 32'd1);
      chk("mis_done_data",  o_mem_rd_data, 32'h0);
      chk("mis_done_stall", 32'(o_stall), 32'd0);
      i_mem_rd_en = 1'b0;
      cyc();
      chk("mis_err_cnt", 32'(o_err_count), 32'd1);
      chk("mis_err_off", 32'(o_err), 32'd0);

      // timeout: no response for 4 bus cycles
      i_mem_rd_en = 1'b1;
      i_mem_addr  = 32'h0000_0040;
      cyc_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         if (o_bus_cyc === 1'b1) cyc_cnt++;
      end
      chk("tmo_cyc_count", 32'(cyc_cnt), 32'd4);
      cyc();
      chk("tmo_done_cyc", 32'(o_bus_cyc), 32'd0);
      chk("tmo_done_err", 32'(o_err), 32'd1);
      chk("tmo_done_stall", 32'(o_stall), 32'd0);
      i_mem_rd_en = 1'b0;
      cyc();
      chk("tmo_err_cnt", 32'(o_err_count), 32'd2);

      // ack on the final allowed cycle counts as success
      i_mem_rd_en = 1'b1;
      i_mem_addr  = 32'h0000_0050;
      cyc();
      cyc();
      cyc();
      cyc();
      chk("late_b4_cyc", 32'(o_bus_cyc), 32'd1);
      i_bus_ack     = 1'b1;
      i_bus_rd_data = 32'hCAFE_F00D;
      cyc();
      i_bus_ack = 1'b0;
      #1;
      chk("late_done_err",  32'(o_err), 32'd0);
      chk("late_done_data", o_mem_rd_data, 32'hCAFE_F00D);
      i_mem_rd_en = 1'b0;
      cyc();
      chk("late_err_cnt", 32'(o_err_count), 32'd2);

      // ack and err together is an error
      i_mem_rd_en = 1'b1;
      i_mem_addr  = 32'h0000_0060;
      cyc();
      i_bus_ack     = 1'b1;
      i_bus_err     = 1'b1;
      i_bus_rd_data = 32'h1111_1111;
      cyc();
      i_bus_ack = 1'b0;
      i_bus_err = 1'b0;
      #1;
      chk("ae_done_err",  32'(o_err), 32'd1);
      chk("ae_done_data", o_mem_rd_data, 32'h0);
      i_mem_rd_en = 1'b0;
      cyc();
      chk("ae_err_cnt", 32'(o_err_count), 32'd3);

      // stray bus responses while idle do nothing
      i_bus_ack = 1'b1;
      i_bus_err = 1'b1;
      cyc();
      chk("stray_cyc",   32'(o_bus_cyc), 32'd0);
      chk("stray_stall", 32'(o_stall), 32'd0);
      i_bus_ack = 1'b0;
      i_bus_err = 1'b0;
      cyc();
      chk("stray_err_cnt", 32'(o_err_count), 32'd3);

      // reset during a bus cycle
      i_mem_rd_en = 1'b1;
      i_mem_addr  = 32'h0000_0070;
      cyc();
      chk("rmb_cyc_before", 32'(o_bus_cyc), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("rmb_cyc_after",  32'(o_bus_cyc), 32'd0);
      chk("rmb_err_cnt",    32'(o_err_count), 32'd0);
      chk("rmb_idle_stall", 32'(o_stall), 32'd1);
      i_mem_rd_en = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      cyc();
      i_mem_rd_en = 1'b1;
      i_mem_addr  = 32'h0000_0080;
      cyc();
      chk("rmb_ld_addr", o_bus_addr, 32'h80);
      i_bus_ack     = 1'b1;
      i_bus_rd_data = 32'hA5A5_A5A5;
      cyc();
      i_bus_ack = 1'b0;
      #1;
      chk("rmb_ld_data", o_mem_rd_data, 32'hA5A5_A5A5);
      chk("rmb_ld_err",  32'(o_err), 32'd0);
      i_mem_rd_en = 1'b0;
      cyc();

      // back-to-back loads with request held throughout
      i_mem_rd_en = 1'b1;
      i_mem_addr  = 32'h0000_0090;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("b2b_idle_cyc",   32'(o_bus_cyc), 32'd0);
         chk("b2b_idle_stall", 32'(o_stall), 32'd1);
         cyc();
         chk("b2b_bus_cyc", 32'(o_bus_cyc), 32'd1);
         i_bus_ack     = 1'b1;
         i_bus_rd_data = 32'h100 + 32'(i);
         cyc();
         i_bus_ack = 1'b0;
         #1;
         chk("b2b_done_data",  o_mem_rd_data, 32'h100 + 32'(i));
         chk("b2b_done_stall", 32'(o_stall), 32'd0);
         chk("b2b_done_cyc",   32'(o_bus_cyc), 32'd0);
         cyc();
      end
      i_mem_rd_en = 1'b0;
      cyc();

      // 300 misaligned accesses saturate the error counter
      i_mem_rd_en = 1'b1;
      i_mem_addr  = 32'h0000_0003;
      for (int i = 0; i < 300; i++) begin
         cyc();
         if (i == 0) chk("sat_first_err", 32'(o_err), 32'd1);
         cyc();
         if (i == 253) chk("sat_cnt_254", 32'(o_err_count), 32'd254);
         if (i == 254) chk("sat_cnt_255", 32'(o_err_count), 32'd255);
         if (i == 299) chk("sat_cnt_hold", 32'(o_err_count), 32'd255);
      end
      i_mem_rd_en = 1'b0;
      cyc();
      cyc();
      chk("sat_final_cnt", 32'(o_err_count), 32'd255);
      chk("sat_final_cyc", 32'(o_bus_cyc), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
